// File: rtl/uart_fifo_core.sv
// uart_fifo_core: single-clock UART with TX and RX FIFOs on the CPU side.
// Bit timing is derived from clk by a down-counting baud timer.
// Ports:
//   clk, rst_n                system clock, async active-low reset
//   rxd / txd                 serial in (async, idle high) / serial out (idle high)
//   wrreq, wdata              push into TX FIFO (dropped when tx_full)
//   tx_full, tx_level         TX FIFO status
//   rdreq, rdata              pop RX FIFO / show-ahead head
//   rx_empty, rx_level        RX FIFO status
//   frame_err, parity_err     1-cycle error pulses from the receiver
//   overrun, err_clr          sticky RX-overflow flag and its clear

// Synchronous FIFO with registered flags and a registered show-ahead head.
// Ports: push_i/wdata_i write, pop_i read, head_o current head,
//        full_o/empty_o/level_o status.
module uart_fifo_sync #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter bit PASS_FULL = 1'b0   // accept a push on full when a pop frees a slot
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop_i & ~empty_q;
        push_ok  = push_i & (~full_q | (PASS_FULL & pop_ok));
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        full_d   = (level_d == LW'(DEPTH));
        empty_d  = (level_d == '0);
        // Head tracks the next entry; it is the incoming word when nothing older
        // remains after this cycle's pop, and it holds its value once empty.
        head_d   = head_q;
        if (!empty_d) begin
            if (push_ok && (level_q == LW'(pop_ok))) head_d = wdata_i;
            else                                     head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;
endmodule

// TX FSM                          | RX FSM
// state  | meaning                | state  | meaning
// IDLE   | line high, await data  | IDLE   | await synchronised 1->0
// START  | drive start bit        | START  | half-bit recheck of start
// DATA   | drive data, LSB first  | DATA   | sample data at bit centres
// PARITY | drive parity bit       | PARITY | sample parity bit
// STOP   | drive stop bit(s)      | STOP   | sample first stop bit
//                                 | BREAK  | bad stop, wait for line high
module uart_fifo_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rxd,
    output logic                        txd,
    input  logic                        wrreq,
    input  logic [DATA_BITS-1:0]        wdata,
    output logic                        tx_full,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    input  logic                        rdreq,
    output logic [DATA_BITS-1:0]        rdata,
    output logic                        rx_empty,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    input  logic                        err_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BAUD_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic          ODD       = (PARITY == 2);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_baud_q, tx_baud_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_pop, tx_empty, tx_tick;
    logic [DATA_BITS-1:0] tx_head;

    uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS), .PASS_FULL(1'b0)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(wrreq), .wdata_i(wdata), .pop_i(tx_pop),
        .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_tick    = (tx_baud_q == '0);
        if (!tx_tick) tx_baud_d = tx_baud_q - CW'(1);
        case (tx_state_q)
            TX_IDLE:  tx_pop = ~tx_empty;
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_baud_d  = BAUD_FULL;
                tx_bit_d   = BW'(DATA_BITS - 1);
            end
            TX_DATA: if (tx_tick) begin
                tx_baud_d = BAUD_FULL;
                if (tx_bit_q == '0) begin
                    tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
                    tx_bit_d   = BW'(STOP_BITS - 1);
                end else begin
                    tx_bit_d   = tx_bit_q - BW'(1);
                    tx_shreg_d = tx_shreg_q >> 1;
                end
            end
            TX_PARITY: if (tx_tick) begin
                tx_state_d = TX_STOP;
                tx_baud_d  = BAUD_FULL;
            end
            TX_STOP: if (tx_tick) begin
                if (tx_bit_q == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    tx_pop     = ~tx_empty;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_bit_d  = tx_bit_q - BW'(1);
                    tx_baud_d = BAUD_FULL;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_d = TX_START;
            tx_baud_d  = BAUD_FULL;
            tx_shreg_d = tx_head;
            tx_par_d   = (^tx_head) ^ ODD;
        end
    end

    // Decoded from registered state so the async reset forces the line high at once.
    always_comb begin
        case (tx_state_q)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_shreg_q[0];
            TX_PARITY: txd = tx_par_q;
            default:   txd = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0]        rx_baud_q, rx_baud_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
    logic                 rx_parbit_q, rx_parbit_d;
    logic                 rx_push_q, rx_push_d;
    logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_tick, rx_full;

    uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS), .PASS_FULL(1'b1)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(rx_push_q), .wdata_i(rx_shreg_q), .pop_i(rdreq),
        .head_o(rdata), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_baud_q    <= '0;
            rx_bit_q     <= '0;
            rx_shreg_q   <= '0;
            rx_parbit_q  <= 1'b0;
            rx_push_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_s1_q      <= rxd;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_baud_q    <= rx_baud_d;
            rx_bit_q     <= rx_bit_d;
            rx_shreg_q   <= rx_shreg_d;
            rx_parbit_q  <= rx_parbit_d;
            rx_push_q    <= rx_push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_baud_d    = rx_baud_q;
        rx_bit_d     = rx_bit_q;
        rx_shreg_d   = rx_shreg_q;
        rx_parbit_d  = rx_parbit_q;
        rx_push_d    = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        rx_tick      = (rx_baud_q == '0);
        if (!rx_tick) rx_baud_d = rx_baud_q - CW'(1);
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = RX_START;
                rx_baud_d  = BAUD_HALF;
            end
            RX_START: if (rx_tick) begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
                else begin
                    rx_state_d = RX_DATA;
                    rx_baud_d  = BAUD_FULL;
                    rx_bit_d   = BW'(DATA_BITS - 1);
                end
            end
            RX_DATA: if (rx_tick) begin
                rx_shreg_d = {rx_s2_q, rx_shreg_q[DATA_BITS-1:1]};
                rx_baud_d  = BAUD_FULL;
                if (rx_bit_q == '0) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                else                rx_bit_d   = rx_bit_q - BW'(1);
            end
            RX_PARITY: if (rx_tick) begin
                rx_parbit_d = rx_s2_q;
                rx_baud_d   = BAUD_FULL;
                rx_state_d  = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                if (!rx_s2_q) begin
                    frame_err_d = 1'b1;
                    rx_state_d  = RX_BREAK;
                end else begin
                    rx_state_d = RX_IDLE;
                    if ((PARITY != 0) && (rx_parbit_q != ((^rx_shreg_q) ^ ODD))) parity_err_d = 1'b1;
                    else                                                        rx_push_d    = 1'b1;
                end
            end
            RX_BREAK: if (rx_s2_q) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
        // A new loss outranks a clear arriving in the same cycle.
        overrun_d = (rx_push_q & rx_full & ~rdreq) | (overrun_q & ~err_clr);
    end

    always_comb begin
        frame_err  = frame_err_q;
        parity_err = parity_err_q;
        overrun    = overrun_q;
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
module tb_uart_fifo_core;
    localparam int CPB   = 8;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          loop;
    logic          rxd_drv0, rxd_drv1;
    logic          rxd0, txd0, txd1;
    logic          wrreq0, rdreq0, err_clr0;
    logic          wrreq1, rdreq1, err_clr1;
    logic [DB-1:0] wdata0, wdata1, rdata0, rdata1;
    logic          tx_full0, rx_empty0, frame_err0, parity_err0, overrun0;
    logic          tx_full1, rx_empty1, frame_err1, parity_err1, overrun1;
    logic [LW-1:0] tx_level0, rx_level0, tx_level1, rx_level1;

    int n_cmp = 0;
    int n_bad = 0;
    int ferr0 = 0, perr0 = 0, ferr1 = 0, perr1 = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par_flip;
        logic       stop_b;
        logic       exp_ferr;
        logic       exp_perr;
        logic       exp_push;
    } vec_t;
    vec_t vecs[9];

    logic [7:0] ov_bytes[5];

    assign rxd0 = loop ? txd0 : rxd_drv0;

    uart_fifo_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd0), .txd(txd0), .wrreq(wrreq0), .wdata(wdata0),
        .tx_full(tx_full0), .tx_level(tx_level0), .rdreq(rdreq0), .rdata(rdata0),
        .rx_empty(rx_empty0), .rx_level(rx_level0), .frame_err(frame_err0),
        .parity_err(parity_err0), .overrun(overrun0), .err_clr(err_clr0)
    );

    uart_fifo_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(1), .STOP_BITS(1),
                     .FIFO_DEPTH(DEPTH)) dut_par (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_drv1), .txd(txd1), .wrreq(wrreq1), .wdata(wdata1),
        .tx_full(tx_full1), .tx_level(tx_level1), .rdreq(rdreq1), .rdata(rdata1),
        .rx_empty(rx_empty1), .rx_level(rx_level1), .frame_err(frame_err1),
        .parity_err(parity_err1), .overrun(overrun1), .err_clr(err_clr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_err0)  ferr0++;
        if (parity_err0) perr0++;
        if (frame_err1)  ferr1++;
        if (parity_err1) perr1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required finish earlier");
        $fatal(1, "time limit");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_txd(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    // One frame on a receiver input, every bit held CPB cycles, line left high.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_flip,
                              input logic stop_b);
        logic [10:0] bits;
        int          n;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (sel == 1) begin
            bits[9]  = (^d) ^ par_flip;
            bits[10] = stop_b;
            n        = 11;
        end else begin
            bits[9]  = stop_b;
            n        = 10;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 0) rxd_drv0 = bits[i];
            else          rxd_drv1 = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        if (sel == 0) rxd_drv0 = 1'b1;
        else          rxd_drv1 = 1'b1;
    endtask

    // Pop every scoreboard entry from the selected RX FIFO and compare.
    task automatic drain(input int sel);
        int         guard;
        logic [7:0] e;
        while ((sel == 0) ? (sb0.size() > 0) : (sb1.size() > 0)) begin
            guard = 0;
            while (((sel == 0) ? rx_empty0 : rx_empty1) && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            check("rx_nonempty", (sel == 0) ? rx_empty0 : rx_empty1, 1'b0);
            if ((sel == 0) ? rx_empty0 : rx_empty1) begin
                if (sel == 0) sb0.delete();
                else          sb1.delete();
            end else begin
                if (sel == 0) e = sb0.pop_front();
                else          e = sb1.pop_front();
                check($sformatf("rdata_dut%0d", sel), (sel == 0) ? rdata0 : rdata1, e);
                if (sel == 0) rdreq0 = 1'b1;
                else          rdreq1 = 1'b1;
                @(negedge clk);
                rdreq0 = 1'b0;
                rdreq1 = 1'b0;
            end
        end
    endtask

    initial begin
        int peak;
        int fb, pb;

        vecs[0] = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ov_bytes = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65};

        rst_n = 1'b0; loop = 1'b0; rxd_drv0 = 1'b1; rxd_drv1 = 1'b1;
        wrreq0 = 1'b0; wdata0 = '0; rdreq0 = 1'b0; err_clr0 = 1'b0;
        wrreq1 = 1'b0; wdata1 = '0; rdreq1 = 1'b0; err_clr1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_txd", txd0, 1'b1);
        check("rst_tx_full", tx_full0, 1'b0);
        check("rst_tx_level", tx_level0, 0);
        check("rst_rx_empty", rx_empty0, 1'b1);
        check("rst_rx_level", rx_level0, 0);
        check("rst_rdata", rdata0, 0);
        check("rst_frame_err", frame_err0, 1'b0);
        check("rst_parity_err", parity_err0, 1'b0);
        check("rst_overrun", overrun0, 1'b0);
        check("rst_txd_p", txd1, 1'b1);
        check("rst_tx_full_p", tx_full1, 1'b0);
        check("rst_tx_level_p", tx_level1, 0);
        check("rst_rx_empty_p", rx_empty1, 1'b1);
        check("rst_rx_level_p", rx_level1, 0);
        check("rst_rdata_p", rdata1, 0);
        check("rst_errs_p", {frame_err1, parity_err1, overrun1}, 0);

        // TX waveform of A5, cycle exact
        wrreq0 = 1'b1; wdata0 = 8'hA5;
        @(negedge clk);
        wrreq0 = 1'b0;
        check("t1_level_push", tx_level0, 1);
        check("t1_txd_idle", txd0, 1'b1);
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            check($sformatf("t1_txd_bit%0d_cyc%0d", i / CPB, i % CPB), txd0, exp_txd(8'hA5, i / CPB));
            if (i == 0) check("t1_level_start", tx_level0, 0);
        end
        repeat (4) @(negedge clk);
        check("t1_txd_after", txd0, 1'b1);

        // Loopback of three back-to-back frames
        loop = 1'b1;
        wrreq0 = 1'b1;
        wdata0 = 8'h00; sb0.push_back(8'h00); @(negedge clk);
        wdata0 = 8'hFF; sb0.push_back(8'hFF); @(negedge clk);
        wdata0 = 8'h5A; sb0.push_back(8'h5A); @(negedge clk);
        wrreq0 = 1'b0;
        peak = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (int'(rx_level0) > peak) peak = int'(rx_level0);
        end
        check("t2_rx_level_peak", peak, 3);
        drain(0);
        check("t2_rx_level_after", rx_level0, 0);
        check("t2_rdata_hold", rdata0, 8'h5A);
        loop = 1'b0;
        repeat (4) @(negedge clk);

        // Short low glitch on rxd is rejected
        fb = ferr0;
        rxd_drv0 = 1'b0;
        repeat (2) @(negedge clk);
        rxd_drv0 = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_rx_level", rx_level0, 0);
        check("glitch_ferr", ferr0 - fb, 0);

        // Table of received frames: good, bad parity, bad stop
        foreach (vecs[k]) begin
            fb = (vecs[k].sel == 0) ? ferr0 : ferr1;
            pb = (vecs[k].sel == 0) ? perr0 : perr1;
            if (vecs[k].exp_push) begin
                if (vecs[k].sel == 0) sb0.push_back(vecs[k].data);
                else                  sb1.push_back(vecs[k].data);
            end
            send_frame(vecs[k].sel, vecs[k].data, vecs[k].par_flip, vecs[k].stop_b);
            repeat (6) @(negedge clk);
            check($sformatf("v%0d_frame_err", k), ((vecs[k].sel == 0) ? ferr0 : ferr1) - fb, vecs[k].exp_ferr);
            check($sformatf("v%0d_parity_err", k), ((vecs[k].sel == 0) ? perr0 : perr1) - pb, vecs[k].exp_perr);
            check($sformatf("v%0d_rx_empty", k), (vecs[k].sel == 0) ? rx_empty0 : rx_empty1, !vecs[k].exp_push);
            drain(vecs[k].sel);
        end

        // Overrun: five frames without reading
        foreach (ov_bytes[k]) begin
            if (k < DEPTH) sb0.push_back(ov_bytes[k]);
            send_frame(0, ov_bytes[k], 1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        check("ov_rx_level", rx_level0, DEPTH);
        check("ov_overrun_set", overrun0, 1'b1);
        err_clr0 = 1'b1;
        @(negedge clk);
        err_clr0 = 1'b0;
        check("ov_overrun_clr", overrun0, 1'b0);
        drain(0);
        check("ov_rx_level_after", rx_level0, 0);

        // TX FIFO fill, drop on full, then reset mid-frame
        wrreq0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata0 = 8'h10 + 8'(i);
            @(negedge clk);
        end
        check("full_tx_full", tx_full0, 1'b1);
        check("full_tx_level", tx_level0, DEPTH);
        wdata0 = 8'h77;
        @(negedge clk);
        wrreq0 = 1'b0;
        check("full_drop_level", tx_level0, DEPTH);
        check("full_txd_start", txd0, 1'b0);
        repeat (20) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_txd", txd0, 1'b1);
        check("midrst_tx_level", tx_level0, 0);
        check("midrst_tx_full", tx_full0, 1'b0);
        check("midrst_rx_level", rx_level0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_txd", txd0, 1'b1);

        // Recovery after reset through loopback
        loop = 1'b1;
        wrreq0 = 1'b1; wdata0 = 8'h96; sb0.push_back(8'h96);
        @(negedge clk);
        wrreq0 = 1'b0;
        repeat (100) @(negedge clk);
        drain(0);
        loop = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
